// File: rtl/memlcd_line_tx.sv
// rtl/memlcd_line_tx.sv - Sharp memory LCD line-update / all-clear serializer
// Optional: define MEMLCD_VCOM_TOGGLE_EN to generate VCOM internally (toggles on each done).
module memlcd_line_tx #(
  parameter int LINE_PIX  = 336,
  parameter int ADDR_W    = 10,
  parameter int LINES     = 536,
  parameter int CLKDIV    = 2,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic                            req_clear,
  input  logic                            vcom,
  output logic                            pix_rd_en,
  output logic [$clog2(LINE_PIX/8)-1:0]   pix_rd_addr,
  input  logic [7:0]                      pix_rd_data,
  output logic                            lcd_scs,
  output logic                            lcd_sclk,
  output logic                            lcd_si,
  output logic                            done,
  output logic                            err
);
  localparam int NB = LINE_PIX / 8;
  localparam int AW = $clog2(NB);
  localparam int BW = $clog2(LINE_PIX + ADDR_W + 17);
  localparam int C1 = (2 * CLKDIV > SETUP_CYC) ? 2 * CLKDIV : SETUP_CYC;
  localparam int C2 = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW = $clog2(((C1 > C2) ? C1 : C2) + 1);

  typedef enum logic [2:0] {IDLE, SETUP, MODE, ADDR, DATA, TRAIL, HOLD, GAP} state_t;

  state_t            state, nst;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitn;
  logic [5:0]        mode_sh;
  logic [ADDR_W-1:0] addr_sh;
  logic [7:0]        cur, nxt;
  logic              rd_pend, clr_q, vcom_src, bad_addr, bit_end, nsi, ld_byte;

`ifdef MEMLCD_VCOM_TOGGLE_EN
  logic vcom_int;
  logic unused_vcom;
  assign unused_vcom = vcom;
  assign vcom_src    = vcom_int;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vcom_int <= 1'b0;
    else if (done) vcom_int <= ~vcom_int;
  end
`else
  assign vcom_src = vcom;
`endif

  assign bad_addr = !req_clear && (req_addr == '0 || 32'(req_addr) > 32'(LINES));
  assign bit_end  = (cnt == CW'(2 * CLKDIV - 1));

  // Value of the bit that follows the current one, and where it comes from.
  always_comb begin
    nst     = state;
    nsi     = 1'b0;
    ld_byte = 1'b0;
    case (state)
      MODE:
        if (bitn == BW'(5)) begin
          nst = ADDR;
          nsi = addr_sh[0];
        end else nsi = mode_sh[1];
      ADDR:
        if (bitn == BW'(ADDR_W - 1)) begin
          if (clr_q) nst = TRAIL;
          else begin
            nst     = DATA;
            nsi     = nxt[0];
            ld_byte = 1'b1;
          end
        end else nsi = addr_sh[1];
      DATA:
        if (bitn == BW'(LINE_PIX - 1)) nst = TRAIL;
        else if (bitn[2:0] == 3'd7) begin
          nsi     = nxt[0];
          ld_byte = 1'b1;
        end else nsi = cur[1];
      TRAIL:
        if (bitn == BW'(15)) nst = HOLD;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  cnt <= '0;  bitn <= '0;  mode_sh <= '0;  addr_sh <= '0;
      cur <= '0;  nxt <= '0;  rd_pend <= 1'b0;  clr_q <= 1'b0;
      req_ready <= 1'b1;  pix_rd_en <= 1'b0;  pix_rd_addr <= '0;
      lcd_scs <= 1'b0;  lcd_sclk <= 1'b0;  lcd_si <= 1'b0;  done <= 1'b0;  err <= 1'b0;
    end else begin
      pix_rd_en <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      rd_pend   <= pix_rd_en;
      if (rd_pend) nxt <= pix_rd_data;
      case (state)
        IDLE:
          if (!req_ready) req_ready <= 1'b1;
          else if (req_valid) begin
            req_ready <= 1'b0;
            if (bad_addr) err <= 1'b1;
            else begin
              state       <= SETUP;
              cnt         <= '0;
              lcd_scs     <= 1'b1;
              clr_q       <= req_clear;
              mode_sh     <= {3'b000, req_clear, vcom_src, !req_clear};
              addr_sh     <= req_clear ? '0 : req_addr;
              pix_rd_en   <= !req_clear;
              pix_rd_addr <= '0;
            end
          end
        SETUP:
          if (cnt == CW'(SETUP_CYC - 1)) begin
            state  <= MODE;
            cnt    <= '0;
            bitn   <= '0;
            lcd_si <= mode_sh[0];
          end else cnt <= cnt + CW'(1);
        MODE, ADDR, DATA, TRAIL: begin
          if (cnt == CW'(CLKDIV - 1)) lcd_sclk <= 1'b1;
          if (bit_end) begin
            cnt      <= '0;
            lcd_sclk <= 1'b0;
            lcd_si   <= nsi;
            state    <= nst;
            bitn     <= (nst != state) ? '0 : bitn + BW'(1);
            if (state == MODE) mode_sh <= {1'b0, mode_sh[5:1]};
            if (state == ADDR) addr_sh <= {1'b0, addr_sh[ADDR_W-1:1]};
            // Loading byte k launches the read of byte k+1 into the next register.
            if (ld_byte) begin
              cur <= nxt;
              if (pix_rd_addr != AW'(NB - 1)) begin
                pix_rd_en   <= 1'b1;
                pix_rd_addr <= pix_rd_addr + AW'(1);
              end
            end else if (state == DATA) cur <= {1'b0, cur[7:1]};
          end else cnt <= cnt + CW'(1);
        end
        HOLD:
          if (cnt == CW'(HOLD_CYC - 1)) begin
            state   <= GAP;
            cnt     <= '0;
            lcd_scs <= 1'b0;
            done    <= (GAP_CYC == 1);
          end else cnt <= cnt + CW'(1);
        GAP:
          if (cnt == CW'(GAP_CYC - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt  <= cnt + CW'(1);
            done <= (cnt == CW'(GAP_CYC - 2));
          end
      endcase
    end
  end
endmodule
